// File: rtl/fp_unit_arbiter_pkg.sv
//----------------------------------------------------------------------------
// Module  : fp_arb_pkg
// Brief   : Shared types and unit indices for the FP unit arbiter.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package fp_arb_pkg;
   typedef enum logic {OP_ADD = 1'b0, OP_MUL = 1'b1} fp_op_e;
   localparam int FP_UNITS = 2;
   localparam int U_MUL    = 1;
   localparam int U_ADD    = 0;
endpackage

`default_nettype wire

// File: rtl/fp_unit_arbiter_rr.sv
//----------------------------------------------------------------------------
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker, first request at/after ptr.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           any
);
   int w_idx;

   // Scan from the farthest offset down so the nearest hit to ptr wins.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      w_idx  = 0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = (int'(ptr) + k) % N;
         if (req[w_idx]) begin
            gnt        = '0;
            gnt[w_idx] = 1'b1;
            gnt_id     = IDW'(w_idx);
            any        = 1'b1;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/fp_unit_arbiter.sv
//----------------------------------------------------------------------------
// Module  : fp_unit_arbiter
// Brief   : Shares one FP multiplier and one FP adder among NUM_REQ requesters.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fp_unit_arbiter
   import fp_arb_pkg::*;
#(
   parameter int DBL_WIDTH = 64,
   parameter int NUM_REQ   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_op,
   input  logic [NUM_REQ*DBL_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*DBL_WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]             req_grant,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [NUM_REQ*DBL_WIDTH-1:0]   rsp_data,
   output logic                           mul_go,
   output logic [DBL_WIDTH-1:0]           mul_a,
   output logic [DBL_WIDTH-1:0]           mul_b,
   input  logic                           mul_ready,
   input  logic                           mul_finish,
   input  logic [DBL_WIDTH-1:0]           mul_r,
   output logic                           add_go,
   output logic [DBL_WIDTH-1:0]           add_a,
   output logic [DBL_WIDTH-1:0]           add_b,
   input  logic                           add_ready,
   input  logic                           add_finish,
   input  logic [DBL_WIDTH-1:0]           add_r,
   output logic [1:0]                     busy,
   output logic                           err_spurious
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]           w_elig_mul, w_elig_add, w_gnt_mul, w_gnt_add;
   logic [NUM_REQ-1:0]           w_req_grant, w_done;
   logic [IDW-1:0]               w_id_mul, w_id_add;
   logic                         w_any_mul, w_any_add;
   logic                         w_grant_mul, w_grant_add, w_fin_mul, w_fin_add;

   logic [FP_UNITS-1:0]          r_busy, r_go;
   logic [IDW-1:0]               r_owner_mul, r_owner_add, r_rr_mul, r_rr_add;
   logic [NUM_REQ-1:0]           r_pending, r_rsp_valid;
   logic [NUM_REQ*DBL_WIDTH-1:0] r_rsp_data;
   logic [DBL_WIDTH-1:0]         r_mul_a, r_mul_b, r_add_a, r_add_b;
   logic                         r_err;

   function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
      return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign w_elig_mul[i] = req_valid[i] & (fp_op_e'(req_op[i]) == OP_MUL) & ~r_pending[i];
      assign w_elig_add[i] = req_valid[i] & (fp_op_e'(req_op[i]) == OP_ADD) & ~r_pending[i];
   end

   rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr_mul (
      .req(w_elig_mul), .ptr(r_rr_mul), .gnt(w_gnt_mul), .gnt_id(w_id_mul), .any(w_any_mul)
   );

   rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr_add (
      .req(w_elig_add), .ptr(r_rr_add), .gnt(w_gnt_add), .gnt_id(w_id_add), .any(w_any_add)
   );

   // Grant and finish are mutually exclusive per unit since one needs busy and the other !busy.
   assign w_grant_mul = rst_n & ~r_busy[U_MUL] & mul_ready & w_any_mul;
   assign w_grant_add = rst_n & ~r_busy[U_ADD] & add_ready & w_any_add;
   assign w_fin_mul   = mul_finish & r_busy[U_MUL];
   assign w_fin_add   = add_finish & r_busy[U_ADD];

   assign w_req_grant = ({NUM_REQ{w_grant_mul}} & w_gnt_mul) | ({NUM_REQ{w_grant_add}} & w_gnt_add);
   assign w_done      = ({{(NUM_REQ-1){1'b0}}, w_fin_mul} << r_owner_mul)
                      | ({{(NUM_REQ-1){1'b0}}, w_fin_add} << r_owner_add);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy      <= '0;
         r_go        <= '0;
         r_owner_mul <= '0;
         r_owner_add <= '0;
         r_rr_mul    <= '0;
         r_rr_add    <= '0;
         r_pending   <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_mul_a     <= '0;
         r_mul_b     <= '0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_go[U_MUL] <= w_grant_mul;
         r_go[U_ADD] <= w_grant_add;
         r_pending   <= (r_pending | w_req_grant) & ~w_done;
         r_rsp_valid <= w_done;
         r_err       <= r_err | (mul_finish & ~r_busy[U_MUL]) | (add_finish & ~r_busy[U_ADD]);

         if (w_grant_mul) begin
            r_busy[U_MUL] <= 1'b1;
            r_owner_mul   <= w_id_mul;
            r_rr_mul      <= next_ptr(w_id_mul);
            r_mul_a       <= req_a[int'(w_id_mul)*DBL_WIDTH +: DBL_WIDTH];
            r_mul_b       <= req_b[int'(w_id_mul)*DBL_WIDTH +: DBL_WIDTH];
         end else if (w_fin_mul) begin
            r_busy[U_MUL] <= 1'b0;
            r_rsp_data[int'(r_owner_mul)*DBL_WIDTH +: DBL_WIDTH] <= mul_r;
         end

         if (w_grant_add) begin
            r_busy[U_ADD] <= 1'b1;
            r_owner_add   <= w_id_add;
            r_rr_add      <= next_ptr(w_id_add);
            r_add_a       <= req_a[int'(w_id_add)*DBL_WIDTH +: DBL_WIDTH];
            r_add_b       <= req_b[int'(w_id_add)*DBL_WIDTH +: DBL_WIDTH];
         end else if (w_fin_add) begin
            r_busy[U_ADD] <= 1'b0;
            r_rsp_data[int'(r_owner_add)*DBL_WIDTH +: DBL_WIDTH] <= add_r;
         end
      end
   end

   assign req_grant    = w_req_grant;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign mul_go       = r_go[U_MUL];
   assign add_go       = r_go[U_ADD];
   assign mul_a        = r_mul_a;
   assign mul_b        = r_mul_b;
   assign add_a        = r_add_a;
   assign add_b        = r_add_b;
   assign busy         = {r_busy[U_MUL], r_busy[U_ADD]};
   assign err_spurious = r_err;
endmodule

`default_nettype wire

// File: tb/tb_fp_unit_arbiter.sv
//----------------------------------------------------------------------------
// Module  : tb_fp_unit_arbiter
// Brief   : Randomized scoreboard bench for fp_unit_arbiter with FP unit models.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_fp_unit_arbiter;
   localparam int W = 64;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid, req_op, req_grant, rsp_valid;
   logic [N*W-1:0] req_a, req_b, rsp_data;
   logic           mul_go, add_go, mul_ready, add_ready, mul_finish, add_finish, err_spurious;
   logic [W-1:0]   mul_a, mul_b, add_a, add_b, mul_r, add_r;
   logic [1:0]     busy;

   logic [1:0]     fin_m, force_fin, rdy;
   logic [W-1:0]   ur [2];

   assign mul_finish = fin_m[1] | force_fin[1];
   assign add_finish = fin_m[0] | force_fin[0];
   assign mul_r      = ur[1];
   assign add_r      = ur[0];
   assign mul_ready  = rdy[1];
   assign add_ready  = rdy[0];

   fp_unit_arbiter #(.DBL_WIDTH(W), .NUM_REQ(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .mul_go(mul_go), .mul_a(mul_a), .mul_b(mul_b),
      .mul_ready(mul_ready), .mul_finish(mul_finish), .mul_r(mul_r),
      .add_go(add_go), .add_a(add_a), .add_b(add_b),
      .add_ready(add_ready), .add_finish(add_finish), .add_r(add_r),
      .busy(busy), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state, index 1 = multiplier, 0 = adder.
   bit   [1:0]   m_busy;
   int           m_own [2];
   int           m_rr  [2];
   bit   [N-1:0] m_out;
   bit           m_err;
   logic [W-1:0] exp_q [N][$];
   logic [N-1:0] exp_rsp;
   bit   [1:0]   go_exp;
   logic [W-1:0] go_a [2], go_b [2];

   // Monitor -> driver handoff.
   logic [N-1:0] gnt_seen;
   bit   [1:0]   go_seen;
   logic [W-1:0] u_a [2], u_b [2];

   initial begin
      logic [N-1:0] exp_g, new_rsp, out_pre, elig;
      logic [1:0]   fin;
      bit   [1:0]   busy_pre;
      int           w;
      real          ra, rb;
      m_busy = '0; m_out = '0; m_err = 1'b0; exp_rsp = '0; go_exp = '0;
      gnt_seen = '0; go_seen = '0;
      for (int u = 0; u < 2; u++) begin
         m_own[u] = 0; m_rr[u] = 0; go_a[u] = '0; go_b[u] = '0; u_a[u] = '0; u_b[u] = '0;
      end
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_req_grant", 64'(req_grant), '0);
            chk("rst_rsp_valid", 64'(rsp_valid), '0);
            chk("rst_busy", 64'(busy), '0);
            chk("rst_go", 64'({mul_go, add_go}), '0);
            chk("rst_err", 64'(err_spurious), '0);
            chk("rst_mul_a", mul_a, '0);
            for (int i = 0; i < N; i++) begin
               chk($sformatf("rst_rsp_data%0d", i), rsp_data[i*W +: W], '0);
               exp_q[i].delete();
            end
            m_busy = '0; m_out = '0; m_err = 1'b0; exp_rsp = '0; go_exp = '0;
            m_rr[0] = 0; m_rr[1] = 0;
            gnt_seen = '0; go_seen = '0;
         end else begin
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
            for (int i = 0; i < N; i++) begin
               if (rsp_valid[i]) begin
                  if (exp_q[i].size() == 0) begin
                     n_checks++;
                     n_err++;
                     $display("FAIL rsp_unexpected req=%0d actual=1 expected=0 t=%0t", i, $time);
                  end else begin
                     chk($sformatf("rsp_data%0d", i), rsp_data[i*W +: W], exp_q[i].pop_front());
                  end
               end
            end
            chk("mul_go", 64'(mul_go), 64'(go_exp[1]));
            chk("add_go", 64'(add_go), 64'(go_exp[0]));
            if (mul_go) begin
               chk("mul_a", mul_a, go_a[1]);
               chk("mul_b", mul_b, go_b[1]);
            end
            if (add_go) begin
               chk("add_a", add_a, go_a[0]);
               chk("add_b", add_b, go_b[0]);
            end
            go_seen = {mul_go, add_go};
            u_a[1] = mul_a; u_b[1] = mul_b; u_a[0] = add_a; u_b[0] = add_b;
            chk("busy", 64'(busy), 64'({m_busy[1], m_busy[0]}));
            chk("err_spurious", 64'(err_spurious), 64'(m_err));

            busy_pre = m_busy;
            out_pre  = m_out;
            new_rsp  = '0;
            exp_g    = '0;
            go_exp   = '0;
            fin      = {mul_finish, add_finish};
            for (int u = 0; u < 2; u++) begin
               if (fin[u]) begin
                  if (busy_pre[u]) begin
                     new_rsp[m_own[u]] = 1'b1;
                     m_out[m_own[u]]   = 1'b0;
                     m_busy[u]         = 1'b0;
                  end else begin
                     m_err = 1'b1;
                  end
               end
            end
            for (int u = 0; u < 2; u++) begin
               elig = '0;
               for (int i = 0; i < N; i++)
                  elig[i] = req_valid[i] && (int'(req_op[i]) == u) && !out_pre[i];
               if (!busy_pre[u] && rdy[u] && elig != '0) begin
                  w = -1;
                  for (int k = 0; k < N; k++)
                     if (w < 0 && elig[(m_rr[u] + k) % N]) w = (m_rr[u] + k) % N;
                  exp_g[w]  = 1'b1;
                  m_busy[u] = 1'b1;
                  m_own[u]  = w;
                  m_rr[u]   = (w + 1) % N;
                  m_out[w]  = 1'b1;
                  go_exp[u] = 1'b1;
                  go_a[u]   = req_a[w*W +: W];
                  go_b[u]   = req_b[w*W +: W];
                  ra = $bitstoreal(go_a[u]);
                  rb = $bitstoreal(go_b[u]);
                  exp_q[w].push_back($realtobits((u == 1) ? ra * rb : ra + rb));
               end
            end
            chk("req_grant", 64'(req_grant), 64'(exp_g));
            gnt_seen = req_grant;
            exp_rsp  = new_rsp;
         end
      end
   end

   // Driver-side unit models and requester behaviour.
   int           cnt [2];
   logic [W-1:0] res [2];
   int           lat_fix   = 0;
   bit           stop      = 1'b1;
   bit           rnd_ready = 1'b0;

   task automatic unit_step();
      real a, b;
      for (int u = 0; u < 2; u++) begin
         fin_m[u] = 1'b0;
         if (!rst_n) begin
            cnt[u] = 0;
            continue;
         end
         if (go_seen[u]) begin
            cnt[u] = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5));
            a = $bitstoreal(u_a[u]);
            b = $bitstoreal(u_b[u]);
            res[u] = $realtobits((u == 1) ? a * b : a + b);
         end
         if (cnt[u] > 0) begin
            cnt[u]--;
            if (cnt[u] == 0) begin
               fin_m[u] = 1'b1;
               ur[u]    = res[u];
            end
         end
      end
   endtask

   task automatic new_op(input int i);
      req_valid[i]     = 1'b1;
      req_op[i]        = 1'($urandom % 2);
      req_a[i*W +: W]  = $realtobits(($itor($urandom_range(0, 400)) - 200.0) / 8.0);
      req_b[i*W +: W]  = $realtobits(($itor($urandom_range(0, 400)) - 200.0) / 8.0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      unit_step();
      if (rnd_ready) rdy = {($urandom % 5) != 0, ($urandom % 5) != 0};
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && gnt_seen[i]) begin
            if (!stop && ($urandom % 10) < 6) new_op(i);
            else req_valid[i] = 1'b0;
         end else if (req_valid[i]) begin
            if (!stop && ($urandom % 20) == 0) req_valid[i] = 1'b0;
         end else if (!stop && ($urandom % 10) < 3) begin
            new_op(i);
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((m_out != '0 || req_valid != '0) && t < 100) begin
         tick();
         t++;
      end
      chk("drain", 64'(m_out | req_valid), '0);
   endtask

   initial begin
      int t;
      req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      fin_m = '0; force_fin = '0; rdy = 2'b11;
      ur[0] = '0; ur[1] = '0; res[0] = '0; res[1] = '0; cnt[0] = 0; cnt[1] = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single MUL 3.0 * 2.0 on a 4-cycle unit.
      lat_fix = 4;
      req_valid[0] = 1'b1;
      req_op[0]    = 1'b1;
      req_a[0 +: W] = $realtobits(3.0);
      req_b[0 +: W] = $realtobits(2.0);
      repeat (12) tick();

      // Randomized traffic with random ready and unit latency.
      lat_fix = 0; rnd_ready = 1'b1; stop = 1'b0;
      repeat (2000) tick();
      stop = 1'b1; rnd_ready = 1'b0; rdy = 2'b11;
      drain();

      // Adder back-pressure, then a spurious adder finish.
      rdy = 2'b10;
      req_valid[1] = 1'b1;
      req_op[1]    = 1'b0;
      req_a[W +: W] = $realtobits(1.0);
      req_b[W +: W] = $realtobits(1.0);
      repeat (5) tick();
      rdy = 2'b11;
      drain();
      ur[0] = $realtobits(9.0);
      force_fin[0] = 1'b1;
      tick();
      force_fin[0] = 1'b0;
      repeat (3) tick();

      // Reset while the multiplier is busy, then a late finish.
      lat_fix = 10;
      req_valid[0] = 1'b1;
      req_op[0]    = 1'b1;
      req_a[0 +: W] = $realtobits(5.0);
      req_b[0 +: W] = $realtobits(7.0);
      t = 0;
      while (!gnt_seen[0] && t < 20) begin
         tick();
         t++;
      end
      chk("reset_test_grant", 64'(gnt_seen[0]), 64'(1));
      repeat (3) tick();
      #2 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      ur[1] = $realtobits(35.0);
      force_fin[1] = 1'b1;
      tick();
      force_fin[1] = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule

`default_nettype wire
